add_sub_pipe: RTL and testbench

- Parametrised, elastic-pipelined add/subtract/accumulate unit. It succeeds the single-cycle registered add/sub block.
- Each accepted operation carries an opcode. The block supports stall-tolerant valid/ready flow control and a running accumulator.
- It sits between operand producers and result consumers in the datapath, and drops into any valid/ready stream.

---
 rtl/add_sub_pipe.sv | 70 +++++++
 tb/tb_add_sub_pipe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: elastic valid/ready add/sub/accumulate pipeline with a STAGES-deep result queue.
// Define ADD_SUB_SAT_EN for the saturating build of ADD, SUB and ACC.
module add_sub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   res,
    output logic [WIDTH-1:0] acc
);
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [WIDTH:0]    d [STAGES];
    logic [WIDTH:0]    sum_ab, diff, sum_acc, r;

    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign sum_acc = {1'b0, acc} + {1'b0, a};

`ifdef ADD_SUB_SAT_EN
    always_comb
        r = op == 2'b00 ? (sum_ab[WIDTH]  ? {1'b1, {WIDTH{1'b1}}} : sum_ab)  :
            op == 2'b01 ? (diff[WIDTH]    ? {1'b1, {WIDTH{1'b0}}} : diff)    :
            op == 2'b10 ? (sum_acc[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : sum_acc) :
                          {1'b0, acc};
`else
    always_comb
        r = op == 2'b00 ? sum_ab  :
            op == 2'b01 ? diff    :
            op == 2'b10 ? sum_acc :
                          {1'b0, acc};
`endif

    // A stage moves unless it and every stage after it are full with the consumer stalled.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready || !(&v[STAGES-1:k]);
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign res       = d[STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v   <= '0;
            acc <= '0;
            for (int k = 0; k < STAGES; k++) d[k] <= '0;
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                if (in_valid) d[0] <= r;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
            if (in_valid && in_ready && op[1]) acc <= op[0] ? '0 : r[WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: directed vectors into a scoreboard queue, checked by an independent output monitor.
module tb_add_sub_pipe;
    localparam int W = 8;
    localparam int S = 2;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

`ifdef ADD_SUB_SAT_EN
    localparam logic [W:0] E_ADD = 9'h1FF, E_SUB = 9'h100, E_MAX = 9'h1FF, E_ACC3 = 9'h1FF;
    localparam logic [W-1:0] E_ACCV = 8'hFF;
`else
    localparam logic [W:0] E_ADD = 9'h12C, E_SUB = 9'h1FE, E_MAX = 9'h1FE, E_ACC3 = 9'h12C;
    localparam logic [W-1:0] E_ACCV = 8'd44;
`endif

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [1:0] op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic in_ready, out_valid;
    logic [W:0] res;
    logic [W-1:0] acc;

    int passed = 0, total = 0, mode = 0, cyc = 0;
    bit flushing = 0, hv = 0;
    logic [W:0] held = 0;
    logic [W:0] q[$];

    logic [W-1:0] sa [8] = '{8'd1, 8'd100, 8'd128, 8'd10, 8'd200, 8'd0, 8'd77, 8'd200};
    logic [W-1:0] sb [8] = '{8'd2, 8'd27, 8'd127, 8'd20, 8'd50, 8'd0, 8'd33, 8'd55};
    logic [W:0]   se [8] = '{9'h003, 9'h07F, 9'h0FF, 9'h01E, 9'h0FA, 9'h000, 9'h06E, 9'h0FF};

    add_sub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res), .acc(acc)
    );

    always #5 clk = ~clk;

    // mode 0: consumer always ready, 1: pattern 1,0,0,1, 2: consumer stalled
    always @(negedge clk) begin
        cyc = cyc + 1;
        out_ready = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : (cyc % 4 == 0 || cyc % 4 == 3);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic issue(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W:0] e, bit push);
        @(negedge clk);
        in_valid = 1; op = o; a = x; b = y;
        for (int t = 0; t <= 50; t++) begin
            #1;
            chk("in_ready", in_ready, !(q.size() == S && !out_ready));
            if (in_ready) begin
                if (push) q.push_back(e);
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected accept");
        $fatal(1, "accept timeout");
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic drain();
        for (int t = 0; q.size() != 0 && t < 200; t++) @(negedge clk);
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) hv = 0;
            else begin
                if (hv) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_res", res, held);
                end
                hv = out_valid && !out_ready;
                held = res;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        if (!flushing) begin
                            total++;
                            $display("FAIL unexpected_out: got res=%0h expected no output", res);
                        end
                    end else chk("res", res, q.pop_front());
                end
            end
        end
    end

    initial begin
        #3 rst = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_acc", acc, 0);
        @(negedge clk) rst = 1;
        @(negedge clk) #1 chk("rst_in_ready", in_ready, 1);
        issue(ADD, 200, 100, E_ADD, 1);
        issue(SUB, 5, 7, E_SUB, 1);
        issue(SUB, 7, 5, 9'h002, 1);
        issue(SUB, 9, 9, 9'h000, 1);
        issue(ADD, 255, 255, E_MAX, 1);
        idle();
        drain();
        mode = 1;
        for (int i = 0; i < 8; i++) issue(ADD, sa[i], sb[i], se[i], 1);
        idle();
        drain();
        mode = 0;
        issue(ACC, 100, 55, 9'h064, 1);
        issue(ACC, 100, 7, 9'h0C8, 1);
        issue(ACC, 100, 200, E_ACC3, 1);
        idle();
        #1 chk("acc_after_acc", acc, E_ACCV);
        issue(CLR, 9, 9, {1'b0, E_ACCV}, 1);
        idle();
        #1 chk("acc_after_clr", acc, 0);
        drain();
        mode = 2;
        flushing = 1;
        issue(ACC, 50, 0, 0, 0);
        issue(ADD, 1, 1, 0, 0);
        idle();
        #1 chk("acc_before_flush", acc, 50);
        #2 rst = 0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_res", res, 0);
        chk("flush_acc", acc, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        flushing = 0;
        mode = 0;
        @(negedge clk) #1 chk("flush_in_ready", in_ready, 1);
        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
